mul_cyc_ctrl: RTL
=================

Name: mul_cyc_ctrl

Overview:
- Moore-FSM control unit for the multi-cycle CPU.
- Sequences the fetch, decode, execute, memory and write-back stages one state per cycle.
- Drives the fetch stage's PC/IR load enable (`fecAbl`) and the PC-source select of the first mux.
- Decodes the opcode from the IR into the per-stage enables and write strobes.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_ORI, 6'b001101, or-immediate opcode
- OP_LW, 6'b100011, load-word opcode
- OP_SW, 6'b101011, store-word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_HALT, 6'b111111, halt opcode

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- run  in  1  start pulse, sampled in IDLE only
- irOutOpe  in  6  opcode from the IR
- aluZero  in  1  ALU zero flag, valid in EX
- fecAbl  out  1  PC write and IR load enable
- decAbl  out  1  register-file read / decode enable
- exeAbl  out  1  ALU operand/result register enable
- memAbl  out  1  data-memory access enable
- wbAbl  out  1  register-file write enable
- memWr  out  1  data-memory write strobe (sw only)
- pcSrc  out  2  first-mux select: 00 = PC+4, 01 = branch target, 10 = jump target
- aluOp  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = or
- halted  out  1  core stopped
- illegal  out  1  sticky unknown-opcode flag
- stateOut  out  3  current state, for debug

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state = IDLE; every output = 0; `illegal` cleared.
- Reset mid-instruction aborts it; no enable is asserted in the reset cycle.
- States (3-bit encoding): IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6.
- Outputs are pure functions of the registered state and `irOutOpe` (Moore plus opcode decode). An enable is valid during its state cycle; the target register captures at that cycle's closing edge.

Transitions:
- IDLE: → IF when `run`=1, else stay.
- IF: `fecAbl`=1, `pcSrc`=00. Always → ID.
- ID: `decAbl`=1.
  - `OP_J`: `fecAbl`=1, `pcSrc`=10, → IF.
  - `OP_HALT`: → HALT.
  - Unknown opcode: set `illegal`, treat as NOP, → IF.
  - All others: → EX.
- EX: `exeAbl`=1.
  - R-type: `aluOp`=10, → WB.
  - `OP_ADDI`, `OP_LW`, `OP_SW`: `aluOp`=00. ADDI → WB; LW/SW → MEM.
  - `OP_ORI`: `aluOp`=11, → WB.
  - `OP_BEQ`: `aluOp`=01. If `aluZero`=1: `fecAbl`=1, `pcSrc`=01. → IF either way.
- MEM: `memAbl`=1. `memWr`=1 for SW, which then → IF. LW → WB.
- WB: `wbAbl`=1, → IF.
- HALT: `halted`=1, all enables 0. Exit only via `rst`.

Latencies (IF to next IF, in cycles):
- J, illegal: 2
- BEQ: 3
- R-type, ADDI, ORI: 4
- SW: 4
- LW: 5

Other rules:
- `aluOp`, `pcSrc` and `memWr` are 0 outside the states listed above.
- `run` is ignored outside IDLE.
- The IR is stable from ID onward because `fecAbl` is 0 there, except on a jump/branch write, which ends the instruction.

Optional Feature:
- Macro: `MUL_CYC_CTRL_PERF_EN`.
- With the macro defined:
  - Adds outputs `cycCnt[31:0]` and `insCnt[31:0]`.
  - `cycCnt` increments every cycle that state ≠ IDLE and ≠ HALT.
  - `insCnt` increments on every transition into IF from ID, EX, MEM or WB.
  - Both counters clear on `rst` and wrap modulo 2^32.
- Without the macro: neither port nor either counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package/include file (`ctrlDefs`) holds:
  - the state encodings
  - the opcode constants
  - the `pcSrc` and `aluOp` encodings
- These constants are shared with the ALU-control and datapath stages.
- One natural sub-module, `ctrl_dec`: purely combinational, mapping (state, opcode, `aluZero`) to the enable/select vector. The top level holds the state register and next-state logic.

Test Plan:
- Reset, then `run` pulse, R-type opcode 0x00 → states 0,1,2,3,5,1; `wbAbl` high exactly 1 cycle; `aluOp`=10 in EX; `fecAbl` high only in IF.
- LW (0x23) then SW (0x2B):
  - LW: `memAbl` high 1 cycle, `memWr`=0, then WB, 5 cycles total.
  - SW: `memWr`=1 in MEM, no WB, 4 cycles total.
- BEQ (0x04):
  - `aluZero`=1 → `fecAbl`=1 with `pcSrc`=01 in EX.
  - `aluZero`=0 → `fecAbl`=0 in EX.
  - Both cases return to IF after 3 cycles.
- J (0x02) → `fecAbl`=1, `pcSrc`=10 in ID; next state IF; 2 cycles.
- Opcode 0x3F → HALT, `halted`=1 and all enables 0 for 20 cycles, `run` ignored. Opcode 0x11 → `illegal`=1 (sticky), execution continues.
- `rst` asserted during MEM of LW → next cycle IDLE, no `wbAbl`. With `MUL_CYC_CTRL_PERF_EN`, after 3 R-type instructions `insCnt`=3 and `cycCnt`=12.

Source files
------------

// File: rtl/mul_cyc_ctrl_pkg.sv
// Shared control encodings: states, opcodes, pcSrc/aluOp selects.
// Also used by the ALU-control and datapath stages.
package ctrlDefs;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic       fecAbl;
    logic       decAbl;
    logic       exeAbl;
    logic       memAbl;
    logic       wbAbl;
    logic       memWr;
    logic [1:0] pcSrc;
    logic [1:0] aluOp;
    logic       halted;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) ||
           (op == OP_ORI)   || (op == OP_LW)   ||
           (op == OP_SW)    || (op == OP_BEQ)  ||
           (op == OP_J)     || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/mul_cyc_ctrl_if.sv
// Control bundle between the sequencer and the datapath stages.
// Perf counters exist only with MUL_CYC_CTRL_PERF_EN defined.
interface mul_cyc_ctrl_if;
  logic        run;
  logic [5:0]  irOutOpe;
  logic        aluZero;
  logic        fecAbl;
  logic        decAbl;
  logic        exeAbl;
  logic        memAbl;
  logic        wbAbl;
  logic        memWr;
  logic [1:0]  pcSrc;
  logic [1:0]  aluOp;
  logic        halted;
  logic        illegal;
  logic [2:0]  stateOut;
`ifdef MUL_CYC_CTRL_PERF_EN
  logic [31:0] cycCnt;
  logic [31:0] insCnt;
`endif

  modport master (
    input  run, irOutOpe, aluZero,
    output fecAbl, decAbl, exeAbl, memAbl, wbAbl,
    output memWr, pcSrc, aluOp, halted, illegal,
    output stateOut
`ifdef MUL_CYC_CTRL_PERF_EN
    , output cycCnt, insCnt
`endif
  );

  modport slave (
    output run, irOutOpe, aluZero,
    input  fecAbl, decAbl, exeAbl, memAbl, wbAbl,
    input  memWr, pcSrc, aluOp, halted, illegal,
    input  stateOut
`ifdef MUL_CYC_CTRL_PERF_EN
    , input cycCnt, insCnt
`endif
  );
endinterface

// File: rtl/mul_cyc_ctrl_dec.sv
// ctrl_dec: combinational map of (state, opcode, zero)
// onto the per-stage enable/select vector.
module ctrl_dec
  import ctrlDefs::*;
(
  input  state_e     i_state,
  input  logic [5:0] i_op,
  input  logic       i_zero,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_state)
      S_IF: begin
        o_ctrl.fecAbl = 1'b1;
        o_ctrl.pcSrc  = PC_SEQ;
      end
      S_ID: begin
        o_ctrl.decAbl = 1'b1;
        if (i_op == OP_J) begin
          o_ctrl.fecAbl = 1'b1;
          o_ctrl.pcSrc  = PC_JMP;
        end
      end
      S_EX: begin
        o_ctrl.exeAbl = 1'b1;
        unique case (i_op)
          OP_RTYPE: o_ctrl.aluOp = ALU_FN;
          OP_ORI:   o_ctrl.aluOp = ALU_OR;
          OP_BEQ: begin
            o_ctrl.aluOp = ALU_SUB;
            if (i_zero) begin
              o_ctrl.fecAbl = 1'b1;
              o_ctrl.pcSrc  = PC_BR;
            end
          end
          default:  o_ctrl.aluOp = ALU_ADD;
        endcase
      end
      S_MEM: begin
        o_ctrl.memAbl = 1'b1;
        o_ctrl.memWr  = (i_op == OP_SW);
      end
      S_WB:    o_ctrl.wbAbl  = 1'b1;
      S_HALT:  o_ctrl.halted = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mul_cyc_ctrl.sv
// Multi-cycle CPU control FSM: state register and next-state logic.
// Optional perf counters: define MUL_CYC_CTRL_PERF_EN.
module mul_cyc_ctrl
  import ctrlDefs::*;
(
  input  logic           clk,
  input  logic           rst,
  mul_cyc_ctrl_if.master bus
);

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  ctrl_t  w_ctrl;
  logic   w_bad_op;

  assign w_bad_op = (r_state == S_ID) &&
                    !op_known(bus.irOutOpe);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_bad_op)
        r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.run) w_next = S_IF;
      S_IF:   w_next = S_ID;
      S_ID: begin
        if (bus.irOutOpe == OP_J)         w_next = S_IF;
        else if (bus.irOutOpe == OP_HALT) w_next = S_HALT;
        else if (w_bad_op)                w_next = S_IF;
        else                              w_next = S_EX;
      end
      S_EX: begin
        unique case (bus.irOutOpe)
          OP_RTYPE,
          OP_ADDI,
          OP_ORI:  w_next = S_WB;
          OP_LW,
          OP_SW:   w_next = S_MEM;
          default: w_next = S_IF;
        endcase
      end
      S_MEM: w_next = (bus.irOutOpe == OP_LW) ? S_WB : S_IF;
      S_WB:   w_next = S_IF;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  ctrl_dec u_dec (
    .i_state (r_state),
    .i_op    (bus.irOutOpe),
    .i_zero  (bus.aluZero),
    .o_ctrl  (w_ctrl)
  );

  // Reset forces everything low in the reset cycle itself, even mid-instruction.
  assign bus.fecAbl   = !rst && w_ctrl.fecAbl;
  assign bus.decAbl   = !rst && w_ctrl.decAbl;
  assign bus.exeAbl   = !rst && w_ctrl.exeAbl;
  assign bus.memAbl   = !rst && w_ctrl.memAbl;
  assign bus.wbAbl    = !rst && w_ctrl.wbAbl;
  assign bus.memWr    = !rst && w_ctrl.memWr;
  assign bus.halted   = !rst && w_ctrl.halted;
  assign bus.illegal  = !rst && r_illegal;
  assign bus.pcSrc    = rst ? 2'b00 : w_ctrl.pcSrc;
  assign bus.aluOp    = rst ? 2'b00 : w_ctrl.aluOp;
  assign bus.stateOut = rst ? 3'd0 : r_state;

`ifdef MUL_CYC_CTRL_PERF_EN
  logic [31:0] r_cyc;
  logic [31:0] r_ins;
  logic        w_retire;

  assign w_retire = (w_next == S_IF) &&
                    ((r_state == S_ID) || (r_state == S_EX) ||
                     (r_state == S_MEM) || (r_state == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT)
        r_cyc <= r_cyc + 32'd1;
      if (w_retire)
        r_ins <= r_ins + 32'd1;
    end
  end

  assign bus.cycCnt = rst ? 32'd0 : r_cyc;
  assign bus.insCnt = rst ? 32'd0 : r_ins;
`endif

endmodule
